// File: rtl/uart_pkg.sv
// Shared UART constants and FSM state encoding, used by uart_byte_tx and uart_byte_rx.
package uart_pkg;

  localparam logic [12:0] MCNT_BAUD = 13'd5207;
  localparam logic [12:0] MCNT_HALF = MCNT_BAUD >> 1;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_byte_rx_if.sv
// Receiver-to-fabric byte channel: received byte plus one-cycle done/error strobes.
interface uart_byte_rx_if;

  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_frame_err;
  logic       rx_parity_err;

  modport master (
    output rx_data,
    output rx_done,
    output rx_frame_err,
    output rx_parity_err
  );

  modport slave (
    input rx_data,
    input rx_done,
    input rx_frame_err,
    input rx_parity_err
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous uart_rx pin plus falling-edge detect.
module uart_rx_sync (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic uart_rx,
  output logic rx_sync,
  output logic rx_fall
);

  logic rx_s1_q, rx_s1_d;
  logic rx_s2_q, rx_s2_d;
  logic rx_d_q,  rx_d_d;

  always_comb begin
    rx_s1_d = uart_rx;
    rx_s2_d = rx_s1_q;
    rx_d_d  = rx_s2_q;
  end

  // Reset to the idle (high) line level so leaving reset never fakes a start edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_d_q  <= 1'b1;
    end else begin
      rx_s1_q <= rx_s1_d;
      rx_s2_q <= rx_s2_d;
      rx_d_q  <= rx_d_d;
    end
  end

  assign rx_sync = rx_s2_q;
  assign rx_fall = rx_d_q & ~rx_s2_q;

endmodule

// File: rtl/uart_byte_rx.sv
// UART 8N1 byte receiver (8E1 when UART_RX_PARITY_EN is defined) with mid-bit sampling.
module uart_byte_rx #(
  parameter logic [12:0] MCNT_BAUD = uart_pkg::MCNT_BAUD,
  parameter logic [12:0] MCNT_HALF = MCNT_BAUD >> 1
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  input  logic           uart_rx,
  uart_byte_rx_if.master rx_bus
);

  import uart_pkg::*;

  logic rx_sync;
  logic rx_fall;

  uart_rx_sync u_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .uart_rx   (uart_rx),
    .rx_sync   (rx_sync),
    .rx_fall   (rx_fall)
  );

  uart_state_e state_q, state_d;
  logic [12:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_done_q, rx_done_d;
  logic        frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic        parity_bit_q, parity_bit_d;
  logic        parity_err_q, parity_err_d;
`endif

  logic sample_stb;
  logic bit_end;

  assign sample_stb = (baud_cnt_q == MCNT_HALF);
  assign bit_end    = (baud_cnt_q == MCNT_BAUD);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bit_d = parity_bit_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        bit_cnt_d = 4'd0;
        if (rx_fall) begin
          state_d = START;
        end
      end
      START: begin
        if (sample_stb && (rx_sync != START_BIT)) begin
          state_d = IDLE;
        end else if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (sample_stb) begin
          shreg_d = {rx_sync, shreg_q[7:1]};
        end
        if (bit_end) begin
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = 4'd0;
`ifdef UART_RX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (sample_stb) begin
          parity_bit_d = rx_sync;
        end
        if (bit_end) begin
          state_d = STOP;
        end
      end
`endif
      // Leave at mid-stop so a start edge half a bit later is still caught.
      STOP: begin
        if (sample_stb) begin
          state_d = IDLE;
          if (rx_sync != STOP_BIT) begin
            frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (parity_bit_q != ^shreg_q) begin
            parity_err_d = 1'b1;
`endif
          end else begin
            rx_data_d = shreg_q;
            rx_done_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if ((state_q == IDLE) || (state_d == IDLE) || bit_end) begin
      baud_cnt_d = 13'd0;
    end else begin
      baud_cnt_d = baud_cnt_q + 13'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      baud_cnt_q  <= 13'd0;
      bit_cnt_q   <= 4'd0;
      shreg_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      parity_bit_q <= parity_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_bus.rx_data      = rx_data_q;
  assign rx_bus.rx_done      = rx_done_q;
  assign rx_bus.rx_frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign rx_bus.rx_parity_err = parity_err_q;
`else
  assign rx_bus.rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_byte_rx.sv
// Scoreboard bench for uart_byte_rx at a shortened 16-cycle bit period.
module tb_uart_byte_rx;

  localparam int BIT = 16;
  localparam int LAT_NOM = 2 + 1 + 7 + 9 * BIT;

  typedef struct {
    logic [1:0] kind;
    logic [7:0] data;
  } exp_t;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic uart_rx = 1'b1;

  uart_byte_rx_if rx_if ();

  uart_byte_rx #(
    .MCNT_BAUD (13'd15),
    .MCNT_HALF (13'd7)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .uart_rx   (uart_rx),
    .rx_bus    (rx_if)
  );

  always #5 sys_clk = ~sys_clk;

  int   cycle_cnt = 0;
  int   start_cycle = 0;
  int   err_count = 0;
  int   check_count = 0;
  logic check_lat = 1'b0;
  logic prev_evt = 1'b0;
  logic [7:0] last_good = 8'h00;
  exp_t sb[$];

  always @(posedge sys_clk) cycle_cnt <= cycle_cnt + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one frame and record what the receiver should report for it.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                               input logic par_en, input logic par_bit);
    exp_t e;
    if (stop_bit == 1'b0) begin
      e.kind = 2'd1;
      e.data = last_good;
    end else if (par_en && (par_bit != ^data)) begin
      e.kind = 2'd2;
      e.data = last_good;
    end else begin
      e.kind = 2'd0;
      e.data = data;
      last_good = data;
    end
    sb.push_back(e);
    uart_rx = 1'b0;
    start_cycle = cycle_cnt;
    repeat (BIT) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = data[i];
      repeat (BIT) @(negedge sys_clk);
    end
    if (par_en) begin
      uart_rx = par_bit;
      repeat (BIT) @(negedge sys_clk);
    end
    uart_rx = stop_bit;
    repeat (BIT) @(negedge sys_clk);
  endtask

  task automatic idleBits(input int n);
    uart_rx = 1'b1;
    repeat (n * BIT) @(negedge sys_clk);
  endtask

  always @(negedge sys_clk) begin
    logic evt;
    logic [1:0] kind;
    exp_t e;
    evt = rx_if.rx_done | rx_if.rx_frame_err | rx_if.rx_parity_err;
    if (!sys_rst_n) begin
      prev_evt <= 1'b0;
    end else begin
      if (evt) begin
        kind = rx_if.rx_done ? 2'd0 : (rx_if.rx_frame_err ? 2'd1 : 2'd2);
        checkOutput("pulse_width", {31'd0, prev_evt}, 32'd0);
        checkOutput("done_ferr_excl", {31'd0, rx_if.rx_done & rx_if.rx_frame_err}, 32'd0);
        if (sb.size() == 0) begin
          checkOutput("unexpected_evt", {30'd0, kind}, 32'd3);
        end else begin
          e = sb.pop_front();
          checkOutput("evt_kind", {30'd0, kind}, {30'd0, e.kind});
          checkOutput("rx_data", {24'd0, rx_if.rx_data}, {24'd0, e.data});
          if (check_lat && rx_if.rx_done) begin
            checkOutput("latency_in_range",
                        {31'd0, ((cycle_cnt - start_cycle) >= LAT_NOM - 1) &&
                                ((cycle_cnt - start_cycle) <= LAT_NOM + 1)}, 32'd1);
          end
        end
      end
      prev_evt <= evt;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge sys_clk);
    checkOutput("rst_data", {24'd0, rx_if.rx_data}, 32'h00);
    checkOutput("rst_done", {31'd0, rx_if.rx_done}, 32'd0);
    checkOutput("rst_ferr", {31'd0, rx_if.rx_frame_err}, 32'd0);
    checkOutput("rst_perr", {31'd0, rx_if.rx_parity_err}, 32'd0);
    sys_rst_n = 1'b1;
    idleBits(2);

    $display("[TB] single frame 0x55");
    check_lat = 1'b1;
    applyStimulus(8'h55, 1'b1, 1'b0, 1'b0);
    idleBits(2);
    check_lat = 1'b0;
    checkOutput("t1_drain", sb.size(), 32'd0);

    $display("[TB] start-bit glitch");
    uart_rx = 1'b0;
    repeat (4) @(negedge sys_clk);
    idleBits(3);
    checkOutput("glitch_data", {24'd0, rx_if.rx_data}, 32'h55);

    $display("[TB] framing error with break");
    applyStimulus(8'h3C, 1'b1, 1'b0, 1'b0);
    idleBits(1);
    applyStimulus(8'hA3, 1'b0, 1'b0, 1'b0);
    repeat (3 * BIT) @(negedge sys_clk);
    idleBits(2);
    checkOutput("ferr_data_held", {24'd0, rx_if.rx_data}, 32'h3C);
    applyStimulus(8'h0F, 1'b1, 1'b0, 1'b0);
    idleBits(2);
    checkOutput("t3_drain", sb.size(), 32'd0);

    $display("[TB] back-to-back frames");
    applyStimulus(8'hA3, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h0F, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0);
    idleBits(2);
    checkOutput("t4_drain", sb.size(), 32'd0);

    $display("[TB] reset mid-frame");
    uart_rx = 1'b0;
    repeat (BIT) @(negedge sys_clk);
    for (int i = 0; i < 4; i++) begin
      uart_rx = (8'h81 >> i) & 8'h01;
      repeat (BIT) @(negedge sys_clk);
    end
    uart_rx = 1'b0;
    repeat (BIT / 2) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    checkOutput("midrst_data", {24'd0, rx_if.rx_data}, 32'h00);
    checkOutput("midrst_done", {31'd0, rx_if.rx_done}, 32'd0);
    checkOutput("midrst_ferr", {31'd0, rx_if.rx_frame_err}, 32'd0);
    last_good = 8'h00;
    @(negedge sys_clk);
    idleBits(2);
    sys_rst_n = 1'b1;
    idleBits(2);
    applyStimulus(8'h7E, 1'b1, 1'b0, 1'b0);
    idleBits(2);
    checkOutput("t5_data", {24'd0, rx_if.rx_data}, 32'h7E);

`ifdef UART_RX_PARITY_EN
    $display("[TB] parity frames");
    applyStimulus(8'h07, 1'b1, 1'b1, 1'b0);
    idleBits(2);
    checkOutput("perr_data_held", {24'd0, rx_if.rx_data}, 32'h7E);
    applyStimulus(8'h07, 1'b1, 1'b1, 1'b1);
    idleBits(2);
`endif

    checkOutput("final_drain", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
